// File: rtl/equiv_sweep_checker.sv
// Exhaustive stimulus/response harness: drives every input vector to two netlists and compares their outputs.
// Optional macro EQV_MISMATCH_COUNT_EN: keep sweeping past mismatches and count them in mism_cnt.
module equiv_sweep_checker #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  vec_out,
  input  logic [N_OUT-1:0] out_a,
  input  logic [N_OUT-1:0] out_b,
  output logic             busy,
  output logic             done,
  output logic             equiv,
  output logic [N_IN-1:0]  mism_vec,
  output logic [N_OUT-1:0] mism_mask,
  output logic [N_IN:0]    mism_cnt
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("equiv_sweep_checker: SETTLE must be in 1..15");
  end
  if (N_IN < 1 || N_IN > 16) begin : g_bad_n_in
    $error("equiv_sweep_checker: N_IN must be in 1..16");
  end
  if (N_OUT < 1 || N_OUT > 32) begin : g_bad_n_out
    $error("equiv_sweep_checker: N_OUT must be in 1..32");
  end

  typedef enum logic [1:0] {IDLE, DRIVE, COMPARE, DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t           state, state_d;
  logic [3:0]       settle_cnt, settle_cnt_d;
  logic [N_IN-1:0]  vec_d, mism_vec_d;
  logic [N_OUT-1:0] mism_mask_d, diff;
  logic             busy_d, done_d, equiv_d;

`ifdef EQV_MISMATCH_COUNT_EN
  localparam logic [N_IN:0] CNT_MAX = {1'b1, {N_IN{1'b0}}};
  logic [N_IN:0] mism_cnt_q, mism_cnt_d;
  assign mism_cnt = mism_cnt_q;
`else
  assign mism_cnt = '0;
`endif

  assign diff = out_a ^ out_b;

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d      = state;
    vec_d        = vec_out;
    settle_cnt_d = settle_cnt;
    busy_d       = busy;
    done_d       = done;
    equiv_d      = equiv;
    mism_vec_d   = mism_vec;
    mism_mask_d  = mism_mask;
`ifdef EQV_MISMATCH_COUNT_EN
    mism_cnt_d   = mism_cnt_q;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          vec_d        = '0;
          settle_cnt_d = SETTLE_LOAD;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          equiv_d      = 1'b0;
          mism_vec_d   = '0;
          mism_mask_d  = '0;
`ifdef EQV_MISMATCH_COUNT_EN
          mism_cnt_d   = '0;
`endif
          state_d      = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == 4'd0) state_d = COMPARE;
        else                    settle_cnt_d = settle_cnt - 4'd1;
      end
      COMPARE: begin
`ifdef EQV_MISMATCH_COUNT_EN
        if (|diff) begin
          if (mism_cnt_q == '0) begin
            mism_vec_d  = vec_out;
            mism_mask_d = diff;
          end
          if (mism_cnt_q != CNT_MAX) mism_cnt_d = mism_cnt_q + 1'b1;
        end
        if (&vec_out) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          equiv_d = (mism_cnt_d == '0);
          state_d = DONE;
        end else begin
          vec_d        = vec_out + 1'b1;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = DRIVE;
        end
`else
        if (|diff) begin
          mism_vec_d  = vec_out;
          mism_mask_d = diff;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          equiv_d     = 1'b0;
          state_d     = DONE;
        end else if (&vec_out) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          equiv_d = 1'b1;
          state_d = DONE;
        end else begin
          vec_d        = vec_out + 1'b1;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = DRIVE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec_out    <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      equiv      <= 1'b0;
      mism_vec   <= '0;
      mism_mask  <= '0;
`ifdef EQV_MISMATCH_COUNT_EN
      mism_cnt_q <= '0;
`endif
    end else begin
      state      <= state_d;
      vec_out    <= vec_d;
      settle_cnt <= settle_cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      equiv      <= equiv_d;
      mism_vec   <= mism_vec_d;
      mism_mask  <= mism_mask_d;
`ifdef EQV_MISMATCH_COUNT_EN
      mism_cnt_q <= mism_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Directed bench for equiv_sweep_checker: one SETTLE=1 instance and one SETTLE=3 instance,
// each fed by small behavioural netlist models.
module tb_equiv_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start3 = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] vec1, mvec1, mmask1, oa1, ob1;
  logic [2:0] mcnt1;
  logic       busy1, done1, equiv1;
  logic [1:0] vec3, mvec3, mmask3, oa3, ob3;
  logic [2:0] mcnt3;
  logic       busy3, done3, equiv3;

  equiv_sweep_checker #(.N_IN(2), .N_OUT(2), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start1), .vec_out(vec1), .out_a(oa1), .out_b(ob1),
    .busy(busy1), .done(done1), .equiv(equiv1), .mism_vec(mvec1), .mism_mask(mmask1),
    .mism_cnt(mcnt1));

  equiv_sweep_checker #(.N_IN(2), .N_OUT(2), .SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start3), .vec_out(vec3), .out_a(oa3), .out_b(ob3),
    .busy(busy3), .done(done3), .equiv(equiv3), .mism_vec(mvec3), .mism_mask(mmask3),
    .mism_cnt(mcnt3));

  // mode 0: equivalent pair; mode 1: A drives O1 = ~I1
  int   mode = 0;
  int   phase = 0;
  logic glitch;

  always_comb begin
    oa1 = {(mode == 1) ? ~vec1[1] : vec1[1], vec1[0] | vec1[1]};
    ob1 = {vec1[1], vec1[0] | vec1[1]};
  end

  // B glitches during the first DRIVE cycle of each vector on the SETTLE=3 instance
  always @(posedge clk) begin
    if (start3 && !busy3) phase <= 0;
    else if (busy3)       phase <= (phase + 1) % 4;
  end
  assign glitch = busy3 && (phase == 0);
  always_comb begin
    oa3 = {vec3[1], vec3[0] | vec3[1]};
    ob3 = oa3 ^ {2{glitch}};
  end

  // Selected-instance views
  bit         sel = 1'b0;
  logic [1:0] d_vec, d_mvec, d_mmask;
  logic [2:0] d_mcnt;
  logic       d_busy, d_done, d_equiv;
  assign d_vec   = sel ? vec3   : vec1;
  assign d_mvec  = sel ? mvec3  : mvec1;
  assign d_mmask = sel ? mmask3 : mmask1;
  assign d_mcnt  = sel ? mcnt3  : mcnt1;
  assign d_busy  = sel ? busy3  : busy1;
  assign d_done  = sel ? done3  : done1;
  assign d_equiv = sel ? equiv3 : equiv1;

  int n_tests = 0;
  int n_fail  = 0;

  int         edges, busy_cycles;
  logic [1:0] vec_log [0:31];
  logic       snap_done, snap_busy;
  logic [1:0] snap_mask, snap_vec;

  // Pulses start and counts edges, the sampling edge being edge 1; edges=0 on timeout.
  task automatic run_sweep(input bit extra);
    @(negedge clk);
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    edges = 0;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges < 32) vec_log[edges] = d_vec;
      if (edges == 1) begin
        snap_done = d_done; snap_busy = d_busy; snap_mask = d_mmask; snap_vec = d_mvec;
      end
      if (d_busy) busy_cycles++;
      if (extra && edges >= 2 && edges <= 5) begin
        if (sel) start3 = 1'b1; else start1 = 1'b1;
      end else begin
        start1 = 1'b0; start3 = 1'b0;
      end
      if (d_done) break;
    end
    start1 = 1'b0; start3 = 1'b0;
    if (!d_done) edges = 0;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({busy1, done1, equiv1, vec1, mvec1, mmask1, mcnt1} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_s1: got %b expected all zero", {busy1, done1, equiv1, vec1, mvec1, mmask1, mcnt1});
    end
    n_tests++;
    if ({busy3, done3, equiv3, vec3, mvec3, mmask3, mcnt3} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_s3: got %b expected all zero", {busy3, done3, equiv3, vec3, mvec3, mmask3, mcnt3});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_equivalent();
    sel = 1'b0; mode = 0;
    run_sweep(1'b0);
    n_tests++;
    if (edges !== 9) begin n_fail++; $display("FAIL equiv_latency: got %0d expected 9", edges); end
    n_tests++;
    if (d_equiv !== 1'b1) begin n_fail++; $display("FAIL equiv_flag: got %b expected 1", d_equiv); end
    n_tests++;
    if (busy_cycles !== 8) begin n_fail++; $display("FAIL equiv_busy_cycles: got %0d expected 8", busy_cycles); end
    for (int k = 1; k <= 8; k++) begin
      n_tests++;
      if (vec_log[k] !== 2'((k - 1) / 2)) begin
        n_fail++;
        $display("FAIL equiv_vec_step%0d: got %0d expected %0d", k, vec_log[k], (k - 1) / 2);
      end
    end
    n_tests++;
    if ({d_busy, d_vec} !== 3'b011) begin n_fail++; $display("FAIL equiv_done_state: got busy,vec=%b expected 011", {d_busy, d_vec}); end
  endtask

  task automatic check_mismatch_result(input string tag);
`ifdef EQV_MISMATCH_COUNT_EN
    n_tests++;
    if (edges !== 9) begin n_fail++; $display("FAIL %s_latency: got %0d expected 9", tag, edges); end
    n_tests++;
    if (d_mcnt !== 3'd4) begin n_fail++; $display("FAIL %s_cnt: got %0d expected 4", tag, d_mcnt); end
    n_tests++;
    if (d_vec !== 2'd3) begin n_fail++; $display("FAIL %s_vec_out: got %0d expected 3", tag, d_vec); end
`else
    n_tests++;
    if (edges !== 3) begin n_fail++; $display("FAIL %s_latency: got %0d expected 3", tag, edges); end
    n_tests++;
    if (d_mcnt !== 3'd0) begin n_fail++; $display("FAIL %s_cnt: got %0d expected 0", tag, d_mcnt); end
    n_tests++;
    if (d_vec !== 2'd0) begin n_fail++; $display("FAIL %s_vec_out: got %0d expected 0", tag, d_vec); end
`endif
    n_tests++;
    if ({d_equiv, d_mvec, d_mmask} !== 5'b0_00_10) begin
      n_fail++;
      $display("FAIL %s_result: got equiv,vec,mask=%b expected 00010", tag, {d_equiv, d_mvec, d_mmask});
    end
  endtask

  task automatic test_mismatch();
    sel = 1'b0; mode = 1;
    run_sweep(1'b0);
    check_mismatch_result("mismatch");
  endtask

  task automatic test_reset_mid_sweep();
    sel = 1'b0; mode = 0;
    @(negedge clk);
    start1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 start1 = 1'b0;
    end
    // Now in the third DRIVE cycle (vector 2)
    n_tests++;
    if ({busy1, vec1} !== 3'b110) begin n_fail++; $display("FAIL midsweep_pre: got busy,vec=%b expected 110", {busy1, vec1}); end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy1, done1, vec1} !== 4'd0) begin n_fail++; $display("FAIL midsweep_reset: got busy,done,vec=%b expected 0000", {busy1, done1, vec1}); end
    @(negedge clk);
    rst = 1'b0;
    run_sweep(1'b0);
    n_tests++;
    if ({edges, d_equiv} !== {32'd9, 1'b1}) begin n_fail++; $display("FAIL midsweep_fresh: got edges=%0d equiv=%b expected 9,1", edges, d_equiv); end
  endtask

  task automatic test_start_ignored_and_restart();
    sel = 1'b0; mode = 0;
    run_sweep(1'b1);
    n_tests++;
    if ({edges, d_equiv} !== {32'd9, 1'b1}) begin n_fail++; $display("FAIL ignored_start: got edges=%0d equiv=%b expected 9,1", edges, d_equiv); end
    mode = 1;
    run_sweep(1'b0);
    check_mismatch_result("restart_first");
    run_sweep(1'b0);
    n_tests++;
    if ({snap_done, snap_busy, snap_vec, snap_mask} !== 6'b01_00_00) begin
      n_fail++;
      $display("FAIL restart_clear: got done,busy,vec,mask=%b expected 010000", {snap_done, snap_busy, snap_vec, snap_mask});
    end
    check_mismatch_result("restart_repeat");
  endtask

  task automatic test_settle3();
    sel = 1'b1;
    run_sweep(1'b0);
    n_tests++;
    if (edges !== 17) begin n_fail++; $display("FAIL settle3_latency: got %0d expected 17", edges); end
    n_tests++;
    if ({d_equiv, d_mcnt, d_mmask} !== 6'b1_000_00) begin
      n_fail++;
      $display("FAIL settle3_result: got equiv,cnt,mask=%b expected 100000", {d_equiv, d_mcnt, d_mmask});
    end
  endtask

  initial begin
    test_reset();
    test_equivalent();
    test_mismatch();
    test_reset_mid_sweep();
    test_start_ignored_and_restart();
    test_settle3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
